ch3_wave_sequencer: RTL and testbench
=====================================

Name: ch3_wave_sequencer

Overview:
Channel-3 playback controller for the 16-byte wave RAM and its sample latches.
- Runs the 11-bit frequency timer and the 5-bit sample position.
- Issues the wave RAM fetch and latch strobes, and drives the nibble select.
- Arbitrates CPU FF3x accesses against playback, with DMG semantics: the CPU is redirected to the playing byte only during the fetch cycle, and blocked otherwise while active.

Parameters:
DIV, 2, clock cycles per frequency-timer tick (timer tick rate = clock/DIV)
TRIG_DELAY, 3, extra timer ticks before the first step after trigger

Ports:
amuk_4mhz  in  1  APU clock; all state on rising edge
apu_reset  in  1  asynchronous, active-high reset
dac_en     in  1  NR30 bit 7; low forces channel inactive
trigger    in  1  one-cycle NR34 trigger pulse
len_stop   in  1  one-cycle length-expiry pulse
freq       in  11 NR33/NR34 frequency value
cpu_addr   in  4  CPU byte address within FF30-FF3F
cpu_rd     in  1  CPU read of FF3x this cycle
cpu_wr     in  1  CPU write of FF3x this cycle
ram_addr   out 4  wave RAM byte address
ram_rd     out 1  wave RAM read enable
ram_wr     out 1  wave RAM write enable
sample_ld  out 1  one-cycle strobe to sample latches (capture wave_rd_d)
nibble_sel out 1  0 = high nibble, 1 = low nibble (pos[0])
ch3_active out 1  channel playing
cpu_rd_ok  out 1  0 = CPU read returns 0xFF

Behaviour:
Reset (async, apu_reset=1):
- ch3_active, ram_rd, ram_wr, sample_ld, nibble_sel, cpu_rd_ok = 0
- pos = 0, timer = 0, prescaler = 0, pending fetch cleared
- Release is synchronous to the next rising edge.

Tick prescaler:
- Mod-DIV counter; emits tick when its count = DIV-1.
- Runs only while ch3_active.

Frequency timer (11-bit up counter):
- On tick: if timer == 2047, reload timer <= freq and emit step; else timer+1.
- Period = (2048-freq) ticks. freq=2047 steps every tick; freq=0 steps every 2048 ticks.
- freq changes take effect only at the next reload.

Trigger:
- trigger & dac_en:
  - ch3_active <= 1, pos <= 0, prescaler <= 0.
  - timer <= freq - TRIG_DELAY, mod 2048; first step after (2048-freq)+TRIG_DELAY ticks.
  - Sample latches are not refreshed; the old sample keeps playing until the first step.
- trigger while active: full restart as above.
- trigger & !dac_en: ignored.

Stop:
- dac_en=0 or len_stop=1: ch3_active <= 0 next edge.
- pos and timer frozen; pending fetch cancelled.
- Stop and trigger in the same cycle: stop wins.

Step (while active):
- pos <= pos+1, wrapping 31 -> 0.
- Fetch cycle is the cycle after step: ram_rd=1, ram_addr=new pos[4:1].
- sample_ld=1 in the cycle after the fetch cycle.
- nibble_sel = pos[0], registered.

CPU arbitration:
- Inactive: pass-through, combinational. ram_addr=cpu_addr, ram_rd=cpu_rd, ram_wr=cpu_wr, cpu_rd_ok=1.
- Active, not the fetch cycle:
  - ram_addr = pos[4:1].
  - cpu_rd gives cpu_rd_ok=0 (reads 0xFF).
  - cpu_wr is dropped (ram_wr=0).
- Active, in the fetch cycle:
  - cpu_rd: ram_addr=pos[4:1], cpu_rd_ok=1. The CPU sees the playing byte regardless of cpu_addr.
  - cpu_wr: ram_wr=1 and ram_rd=0 at pos[4:1]. sample_ld is still issued and captures the written value.
- ram_rd and ram_wr are never both 1.

Decomposition:
Package ch3_pkg:
- TIMER_W=11, POS_W=5, RAM_AW=4, TIMER_MAX=11'h7FF.
- typedef pos_t (logic [4:0]).

Sub-module ch3_freq_timer:
- Contains the prescaler and the 11-bit timer.
- Ports: clock, reset, run, load, load_val, freq, step.
- ch3_wave_sequencer holds pos, fetch pipeline, active flag and arbitration.

Test Plan:
1. Reset mid-playback (active, pos=13) -> all outputs 0 immediately, asynchronously. After release, no ram_rd until a trigger.
2. freq=2047, DIV=2, trigger with dac_en=1:
   - first step 2*(1+3)=8 cycles after trigger;
   - then ram_rd every 2 cycles with ram_addr 0,1,1,2,2,...;
   - sample_ld one cycle after each ram_rd;
   - nibble_sel toggles each step;
   - pos wraps 31 -> 0 and ram_addr returns to 0.
3. freq=2040 -> step spacing exactly 8 ticks = 16 cycles. Change freq to 2044 mid-period -> current period unchanged, next period 4 ticks.
4. CPU access while active:
   - cpu_rd at cpu_addr=5 outside fetch cycle -> cpu_rd_ok=0, ram_rd=0.
   - cpu_rd coincident with fetch at pos=18 -> ram_addr=9, cpu_rd_ok=1.
   - cpu_wr outside fetch -> ram_wr=0.
   - cpu_wr in fetch cycle -> ram_wr=1 at addr 9, ram_rd=0, sample_ld next cycle.
5. Inactive pass-through: cpu_wr at addr 0xC -> ram_wr=1, ram_addr=0xC in the same cycle. cpu_rd -> cpu_rd_ok=1.
6. Stop and retrigger:
   - dac_en=0 while active -> ch3_active=0 next edge, no further ram_rd.
   - trigger with dac_en=0 -> ignored.
   - len_stop and trigger in the same cycle -> inactive.
   - retrigger while active at pos=20 -> pos=0, first fetch at ram_addr=0 after the trigger delay.

Source files
------------

// File: rtl/ch3_pkg.sv
// Shared widths and types for the channel-3 wave playback slice.
// Constants only: no logic, no latency, no backpressure.
// Imported by the frequency timer and the wave sequencer.
package ch3_pkg;

  localparam int TIMER_W = 11;
  localparam int POS_W   = 5;
  localparam int RAM_AW  = 4;
  localparam logic [TIMER_W-1:0] TIMER_MAX = 11'h7FF;

  typedef logic [POS_W-1:0] pos_t;

endpackage

// File: rtl/ch3_freq_timer.sv
// Channel-3 prescaler plus 11-bit up-counting frequency timer; step pulses on wrap.
// Latency: step is combinational in the tick cycle where timer == 2047.
// Backpressure: none; freezes while run is low, load overrides everything else.
module ch3_freq_timer
  import ch3_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  input  logic [TIMER_W-1:0] freq,
  output logic               step
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0]      prescaler;
  logic [TIMER_W-1:0] timer;
  logic               tick;

  assign tick = run && (prescaler == PRE_LAST);
  assign step = tick && (timer == TIMER_MAX);

  // freq is only sampled at the wrap reload, so mid-period writes wait a period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      timer     <= '0;
    end else if (load) begin
      prescaler <= '0;
      timer     <= load_val;
    end else if (run) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        timer <= (timer == TIMER_MAX) ? freq : timer + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ch3_wave_sequencer.sv
// Channel-3 playback controller: sample position, wave RAM fetch/latch strobes, CPU arbitration.
// Latency: fetch one cycle after a step, sample_ld one cycle after the fetch; CPU path combinational.
// Backpressure: none; CPU is redirected in fetch cycles and blocked otherwise while playing.
module ch3_wave_sequencer
  import ch3_pkg::*;
#(
  parameter int DIV        = 2,
  parameter int TRIG_DELAY = 3
) (
  input  logic               amuk_4mhz,
  input  logic               apu_reset,
  input  logic               dac_en,
  input  logic               trigger,
  input  logic               len_stop,
  input  logic [TIMER_W-1:0] freq,
  input  logic [RAM_AW-1:0]  cpu_addr,
  input  logic               cpu_rd,
  input  logic               cpu_wr,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic               ram_rd,
  output logic               ram_wr,
  output logic               sample_ld,
  output logic               nibble_sel,
  output logic               ch3_active,
  output logic               cpu_rd_ok
);

  logic stop;
  logic restart;
  logic step;
  logic fetch;
  pos_t pos;

  // a stop request in the same cycle as a trigger wins
  assign stop    = !dac_en || len_stop;
  assign restart = trigger && !stop;

  ch3_freq_timer #(
    .DIV (DIV)
  ) u_freq_timer (
    .clk      (amuk_4mhz),
    .rst      (apu_reset),
    .run      (ch3_active && !stop),
    .load     (restart),
    .load_val (freq - TIMER_W'(TRIG_DELAY)),
    .freq     (freq),
    .step     (step)
  );

  always_ff @(posedge amuk_4mhz or posedge apu_reset) begin
    if (apu_reset) begin
      ch3_active <= 1'b0;
      pos        <= '0;
      fetch      <= 1'b0;
      sample_ld  <= 1'b0;
    end else begin
      sample_ld <= fetch;
      if (stop) begin
        ch3_active <= 1'b0;
        fetch      <= 1'b0;
      end else if (trigger) begin
        ch3_active <= 1'b1;
        pos        <= '0;
        fetch      <= 1'b0;
      end else begin
        fetch <= step;
        if (step) begin
          pos <= pos + 1'b1;
        end
      end
    end
  end

  assign nibble_sel = pos[0];

  // CPU writes in the fetch cycle replace the playback read so the latch captures the written byte
  always_comb begin
    ram_addr  = '0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;
    cpu_rd_ok = 1'b0;
    if (!apu_reset) begin
      if (!ch3_active) begin
        ram_addr  = cpu_addr;
        ram_wr    = cpu_wr;
        ram_rd    = cpu_rd && !cpu_wr;
        cpu_rd_ok = 1'b1;
      end else begin
        ram_addr = pos[POS_W-1:1];
        if (fetch) begin
          ram_wr    = cpu_wr;
          ram_rd    = !cpu_wr;
          cpu_rd_ok = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
// Bench for ch3_wave_sequencer: directed stimulus pushes expected RAM/latch/CPU events,
// a negedge monitor pops and compares whenever the DUT shows activity.
module tb_ch3_wave_sequencer;

  logic        clk = 1'b0;
  logic        apu_reset;
  logic        dac_en;
  logic        trigger;
  logic        len_stop;
  logic [10:0] freq;
  logic [3:0]  cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [3:0]  ram_addr;
  logic        ram_rd;
  logic        ram_wr;
  logic        sample_ld;
  logic        nibble_sel;
  logic        ch3_active;
  logic        cpu_rd_ok;

  typedef struct packed {
    int         cyc;
    logic [3:0] addr;
    logic       rd;
    logic       wr;
    logic       ld;
    logic       nib;
    logic       ok;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  t;
  int  t3;

  ch3_wave_sequencer #(
    .DIV        (2),
    .TRIG_DELAY (3)
  ) dut (
    .amuk_4mhz  (clk),
    .apu_reset  (apu_reset),
    .dac_en     (dac_en),
    .trigger    (trigger),
    .len_stop   (len_stop),
    .freq       (freq),
    .cpu_addr   (cpu_addr),
    .cpu_rd     (cpu_rd),
    .cpu_wr     (cpu_wr),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_wr     (ram_wr),
    .sample_ld  (sample_ld),
    .nibble_sel (nibble_sel),
    .ch3_active (ch3_active),
    .cpu_rd_ok  (cpu_rd_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input int addr, input logic rd, input logic wr,
                         input logic ld, input logic nib, input logic ok);
    ev_t e;
    e.cyc  = c;
    e.addr = 4'(addr);
    e.rd   = rd;
    e.wr   = wr;
    e.ld   = ld;
    e.nib  = nib;
    e.ok   = ok;
    exp_q.push_back(e);
  endtask

  // fetch for step k reads byte k>>1; the latch strobe follows one cycle later
  task automatic push_step(input int fc, input int k, input logic cpu_write);
    push_ev(fc, k >> 1, !cpu_write, cpu_write, 1'b0, 1'((k % 2) != 0), 1'b1);
    push_ev(fc + 1, k >> 1, 1'b0, 1'b0, 1'b1, 1'((k % 2) != 0), 1'b1);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (ram_rd || ram_wr || sample_ld || cpu_rd || cpu_wr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d addr=%h rd=%b wr=%b ld=%b, none expected",
                 cyc, ram_addr, ram_rd, ram_wr, sample_ld);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.cyc || ram_addr !== e.addr || ram_rd !== e.rd || ram_wr !== e.wr ||
            sample_ld !== e.ld || nibble_sel !== e.nib || (cpu_rd && cpu_rd_ok !== e.ok)) begin
          errors++;
          $display("FAIL event: got cyc=%0d addr=%h rd=%b wr=%b ld=%b nib=%b ok=%b, expected cyc=%0d addr=%h rd=%b wr=%b ld=%b nib=%b ok=%b",
                   cyc, ram_addr, ram_rd, ram_wr, sample_ld, nibble_sel, cpu_rd_ok,
                   e.cyc, e.addr, e.rd, e.wr, e.ld, e.nib, e.ok);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    apu_reset = 1'b1;
    dac_en    = 1'b0;
    trigger   = 1'b0;
    len_stop  = 1'b0;
    freq      = 11'd0;
    cpu_addr  = 4'd0;
    cpu_rd    = 1'b0;
    cpu_wr    = 1'b0;
    next_cyc(3);
    chk("init_active", 32'(ch3_active), 0);
    chk("init_outputs", {ram_rd, ram_wr, sample_ld, nibble_sel, cpu_rd_ok}, 0);
    apu_reset = 1'b0;
    next_cyc(2);

    // playback at fastest rate, reset asynchronously while pos = 13
    dac_en = 1'b1;
    freq   = 11'h7FF;
    t      = cyc + 1;
    for (int k = 1; k <= 12; k++) push_step(t + 8 + 2 * (k - 1), k, 1'b0);
    push_ev(t + 32, 6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    trigger = 1'b1;
    next_cyc(1);
    trigger = 1'b0;
    wait_until(t + 33);
    chk("pre_rst_active", 32'(ch3_active), 1);
    chk("pre_rst_ld", 32'(sample_ld), 1);
    chk("pre_rst_nib", 32'(nibble_sel), 1);
    apu_reset = 1'b1;
    #1;
    chk("async_rst_outputs", {ch3_active, ram_rd, ram_wr, sample_ld, nibble_sel, cpu_rd_ok}, 0);
    chk("async_rst_addr", 32'(ram_addr), 0);
    next_cyc(3);
    apu_reset = 1'b0;
    next_cyc(20);
    chk("post_rst_active", 32'(ch3_active), 0);

    // full wrap with CPU accesses inside and outside fetch cycles, then dac_en stop
    t = cyc + 1;
    push_ev(t + 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_ev(t + 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 33; k++) push_step(t + 8 + 2 * (k - 1), k, k == 19);
    trigger = 1'b1;
    next_cyc(1);
    trigger = 1'b0;
    wait_until(t + 3);
    cpu_rd = 1'b1; cpu_addr = 4'd5;
    next_cyc(1);
    cpu_rd = 1'b0;
    wait_until(t + 5);
    cpu_wr = 1'b1; cpu_addr = 4'd7;
    next_cyc(1);
    cpu_wr = 1'b0;
    wait_until(t + 42);
    cpu_rd = 1'b1; cpu_addr = 4'd3;
    next_cyc(1);
    cpu_rd = 1'b0;
    wait_until(t + 44);
    cpu_wr = 1'b1; cpu_addr = 4'd6;
    next_cyc(1);
    cpu_wr = 1'b0;
    wait_until(t + 73);
    dac_en = 1'b0;
    next_cyc(1);
    chk("dac_stop_active", 32'(ch3_active), 0);
    next_cyc(10);

    // trigger with the DAC off is ignored
    trigger = 1'b1;
    next_cyc(1);
    trigger = 1'b0;
    chk("ign_trig_active", 32'(ch3_active), 0);
    next_cyc(10);

    // inactive pass-through; pos stays frozen at 1
    push_ev(cyc, 12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cpu_wr = 1'b1; cpu_addr = 4'hC;
    next_cyc(1);
    cpu_wr = 1'b0;
    push_ev(cyc, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cpu_rd = 1'b1; cpu_addr = 4'h3;
    next_cyc(1);
    cpu_rd = 1'b0;
    next_cyc(3);

    // freq 2040: 22-cycle first step, 16-cycle period; 2044 applies from the next reload
    dac_en = 1'b1;
    freq   = 11'd2040;
    t      = cyc + 1;
    push_step(t + 22, 1, 1'b0);
    push_step(t + 38, 2, 1'b0);
    for (int k = 3; k <= 20; k++) push_step(t + 38 + 8 * (k - 2), k, 1'b0);
    trigger = 1'b1;
    next_cyc(1);
    trigger = 1'b0;
    wait_until(t + 30);
    freq = 11'd2044;
    wait_until(t + 184);
    freq = 11'h7FF;
    wait_until(t + 185);

    // retrigger at pos = 20 restarts from byte 0
    t3 = t + 186;
    for (int k = 1; k <= 3; k++) push_step(t3 + 8 + 2 * (k - 1), k, 1'b0);
    trigger = 1'b1;
    next_cyc(1);
    trigger = 1'b0;
    chk("retrig_active", 32'(ch3_active), 1);
    chk("retrig_nib", 32'(nibble_sel), 0);
    wait_until(t3 + 13);
    len_stop = 1'b1;
    trigger  = 1'b1;
    next_cyc(1);
    len_stop = 1'b0;
    trigger  = 1'b0;
    chk("stop_wins_active", 32'(ch3_active), 0);
    next_cyc(10);

    chk("exp_q_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
